obi_mem_arbiter: RTL and testbench

OBI_MEM_ARBITER -- requirements
Module: obi_mem_arbiter

---
 rtl/obi_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_obi_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_mem_arbiter.sv
// Two-master OBI arbiter (scalar core + vector LSU) onto one shared memory port.
// Round-robin with a vector lock; an ID FIFO routes in-order responses back to their master.
module obi_mem_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        n_reset,

    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    input  logic [3:0]  core_be_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic [31:0] core_rdata_o,

    input  logic        vlsu_req_i,
    input  logic        vlsu_we_i,
    input  logic [31:0] vlsu_addr_i,
    input  logic [31:0] vlsu_wdata_i,
    input  logic [3:0]  vlsu_be_i,
    output logic        vlsu_gnt_o,
    output logic        vlsu_rvalid_o,
    output logic [31:0] vlsu_rdata_o,

    input  logic        vlsu_lock_i,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,

    output logic        protocol_err_o
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic ID_CORE = 1'b0;
    localparam logic ID_VLSU = 1'b1;

    logic                       last_grant_q;
    logic [MAX_OUTSTANDING-1:0] id_fifo_q;
    logic [PTR_W-1:0]           wr_ptr_q;
    logic [PTR_W-1:0]           rd_ptr_q;
    logic [CNT_W-1:0]           count_q;
    logic                       protocol_err_q;

    logic sel_valid;
    logic sel_id;
    logic fifo_empty;
    logic fifo_full;
    logic head_id;
    logic pop;
    logic stray_rsp;
    logic req_int;
    logic push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        sel_valid = 1'b0;
        sel_id    = ID_CORE;
        if (vlsu_lock_i) begin
            sel_valid = vlsu_req_i;
            sel_id    = ID_VLSU;
        end else if (core_req_i && vlsu_req_i) begin
            sel_valid = 1'b1;
            sel_id    = ~last_grant_q;
        end else if (core_req_i) begin
            sel_valid = 1'b1;
            sel_id    = ID_CORE;
        end else if (vlsu_req_i) begin
            sel_valid = 1'b1;
            sel_id    = ID_VLSU;
        end
    end

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign head_id    = id_fifo_q[rd_ptr_q];
    assign pop        = mem_rvalid_i && !fifo_empty;
    assign stray_rsp  = mem_rvalid_i && fifo_empty;

    // A same-cycle pop frees a slot, so a full FIFO can still accept a new request.
    assign req_int = sel_valid && (!fifo_full || pop);
    assign push    = req_int && mem_gnt_i;

    // Every output is forced low while reset is held, including the combinational paths.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (n_reset && sel_valid) begin
            mem_req_o = req_int;
            if (sel_id == ID_VLSU) begin
                mem_we_o    = vlsu_we_i;
                mem_addr_o  = vlsu_addr_i;
                mem_wdata_o = vlsu_wdata_i;
                mem_be_o    = vlsu_be_i;
            end else begin
                mem_we_o    = core_we_i;
                mem_addr_o  = core_addr_i;
                mem_wdata_o = core_wdata_i;
                mem_be_o    = core_be_i;
            end
        end
    end

    assign core_gnt_o     = n_reset && push && (sel_id == ID_CORE);
    assign vlsu_gnt_o     = n_reset && push && (sel_id == ID_VLSU);
    assign core_rvalid_o  = n_reset && pop && (head_id == ID_CORE);
    assign vlsu_rvalid_o  = n_reset && pop && (head_id == ID_VLSU);
    assign core_rdata_o   = n_reset ? mem_rdata_i : '0;
    assign vlsu_rdata_o   = n_reset ? mem_rdata_i : '0;
    assign protocol_err_o = protocol_err_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            last_grant_q <= ID_VLSU;
            id_fifo_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            if (push) begin
                last_grant_q        <= sel_id;
                id_fifo_q[wr_ptr_q] <= sel_id;
                wr_ptr_q            <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            protocol_err_q <= 1'b0;
        end else if (stray_rsp) begin
            protocol_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed bench for obi_mem_arbiter: inputs driven 1 time unit after the rising edge,
// outputs checked on the falling edge against hand-computed values.
module tb_obi_mem_arbiter;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        core_req, core_we, core_gnt, core_rvalid;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic [3:0]  core_be;
    logic        vlsu_req, vlsu_we, vlsu_gnt, vlsu_rvalid;
    logic [31:0] vlsu_addr, vlsu_wdata, vlsu_rdata;
    logic [3:0]  vlsu_be;
    logic        vlsu_lock;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        protocol_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    obi_mem_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .core_req_i     (core_req),
        .core_we_i      (core_we),
        .core_addr_i    (core_addr),
        .core_wdata_i   (core_wdata),
        .core_be_i      (core_be),
        .core_gnt_o     (core_gnt),
        .core_rvalid_o  (core_rvalid),
        .core_rdata_o   (core_rdata),
        .vlsu_req_i     (vlsu_req),
        .vlsu_we_i      (vlsu_we),
        .vlsu_addr_i    (vlsu_addr),
        .vlsu_wdata_i   (vlsu_wdata),
        .vlsu_be_i      (vlsu_be),
        .vlsu_gnt_o     (vlsu_gnt),
        .vlsu_rvalid_o  (vlsu_rvalid),
        .vlsu_rdata_o   (vlsu_rdata),
        .vlsu_lock_i    (vlsu_lock),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_be_o       (mem_be),
        .mem_gnt_i      (mem_gnt),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata),
        .protocol_err_o (protocol_err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_mem_req"},     32'(mem_req),      32'd0);
        check_val({tag, "_mem_we"},      32'(mem_we),       32'd0);
        check_val({tag, "_mem_addr"},    mem_addr,          32'd0);
        check_val({tag, "_mem_wdata"},   mem_wdata,         32'd0);
        check_val({tag, "_mem_be"},      32'(mem_be),       32'd0);
        check_val({tag, "_core_gnt"},    32'(core_gnt),     32'd0);
        check_val({tag, "_vlsu_gnt"},    32'(vlsu_gnt),     32'd0);
        check_val({tag, "_core_rvalid"}, 32'(core_rvalid),  32'd0);
        check_val({tag, "_vlsu_rvalid"}, 32'(vlsu_rvalid),  32'd0);
        check_val({tag, "_core_rdata"},  core_rdata,        32'd0);
        check_val({tag, "_vlsu_rdata"},  vlsu_rdata,        32'd0);
        check_val({tag, "_perr"},        32'(protocol_err), 32'd0);
    endtask

    task automatic idle();
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0; core_be = '0;
        vlsu_req = 1'b0; vlsu_we = 1'b0; vlsu_addr = '0; vlsu_wdata = '0; vlsu_be = '0;
        vlsu_lock = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setup_masters();
        core_we = 1'b1; core_addr = 32'h1000; core_wdata = 32'h1111_1111; core_be = 4'h3;
        vlsu_we = 1'b0; vlsu_addr = 32'h2000; vlsu_wdata = 32'h2222_2222; vlsu_be = 4'hC;
    endtask

    initial begin
        // Reset with every input active: outputs must all be zero.
        idle();
        n_reset = 1'b0;
        core_req = 1'b1; vlsu_req = 1'b1; core_addr = 32'h40; vlsu_addr = 32'h80;
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        check_all_zero("rst");
        next_cycle();
        idle();
        n_reset = 1'b1;
        @(negedge clk);
        check_val("post_rst_mem_req", 32'(mem_req), 32'd0);
        check_val("post_rst_perr", 32'(protocol_err), 32'd0);

        // Core-only read
        next_cycle();
        core_req = 1'b1; core_addr = 32'h100; core_be = 4'hF; mem_gnt = 1'b1;
        @(negedge clk);
        check_val("c_only_mem_req", 32'(mem_req), 32'd1);
        check_val("c_only_mem_addr", mem_addr, 32'h100);
        check_val("c_only_mem_be", 32'(mem_be), 32'hF);
        check_val("c_only_core_gnt", 32'(core_gnt), 32'd1);
        check_val("c_only_vlsu_gnt", 32'(vlsu_gnt), 32'd0);
        check_val("c_only_vlsu_rv0", 32'(vlsu_rvalid), 32'd0);
        next_cycle();
        idle();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_val("c_only_core_rvalid", 32'(core_rvalid), 32'd1);
        check_val("c_only_core_rdata", core_rdata, 32'hDEAD_BEEF);
        check_val("c_only_vlsu_rv1", 32'(vlsu_rvalid), 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        check_val("c_only_core_rv_off", 32'(core_rvalid), 32'd0);
        check_val("c_only_vlsu_rv2", 32'(vlsu_rvalid), 32'd0);

        // Vector-only read, leaves last_grant on the vector LSU
        next_cycle();
        vlsu_req = 1'b1; vlsu_addr = 32'h2000; mem_gnt = 1'b1;
        @(negedge clk);
        check_val("v_only_vlsu_gnt", 32'(vlsu_gnt), 32'd1);
        check_val("v_only_core_gnt", 32'(core_gnt), 32'd0);
        check_val("v_only_mem_addr", mem_addr, 32'h2000);
        next_cycle();
        idle();
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        check_val("v_only_vlsu_rvalid", 32'(vlsu_rvalid), 32'd1);
        check_val("v_only_vlsu_rdata", vlsu_rdata, 32'hCAFE_0001);
        check_val("v_only_core_rvalid", 32'(core_rvalid), 32'd0);

        // Both requesting: core, vlsu, core, vlsu; responses one cycle behind
        setup_masters();
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            core_req = (i < 4); vlsu_req = (i < 4); mem_gnt = (i < 4);
            mem_rvalid = (i > 0); mem_rdata = 32'hA0 + 32'(i);
            @(negedge clk);
            check_val($sformatf("rr%0d_core_gnt", i), 32'(core_gnt), 32'((i < 4) && (i % 2 == 0)));
            check_val($sformatf("rr%0d_vlsu_gnt", i), 32'(vlsu_gnt), 32'((i < 4) && (i % 2 == 1)));
            if (i < 4) begin
                check_val($sformatf("rr%0d_addr", i), mem_addr, (i % 2 == 0) ? 32'h1000 : 32'h2000);
                check_val($sformatf("rr%0d_wdata", i), mem_wdata, (i % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222);
                check_val($sformatf("rr%0d_be", i), 32'(mem_be), (i % 2 == 0) ? 32'h3 : 32'hC);
                check_val($sformatf("rr%0d_we", i), 32'(mem_we), (i % 2 == 0) ? 32'd1 : 32'd0);
            end
            check_val($sformatf("rr%0d_core_rv", i), 32'(core_rvalid), 32'((i > 0) && ((i - 1) % 2 == 0)));
            check_val($sformatf("rr%0d_vlsu_rv", i), 32'(vlsu_rvalid), 32'((i > 0) && ((i - 1) % 2 == 1)));
            check_val($sformatf("rr%0d_rdata", i), core_rdata, 32'hA0 + 32'(i));
        end

        // Fill to MAX_OUTSTANDING=2, then push and pop together while full
        next_cycle();
        idle();
        setup_masters();
        core_req = 1'b1; mem_gnt = 1'b1;
        @(negedge clk);
        check_val("full_hs1_core_gnt", 32'(core_gnt), 32'd1);
        next_cycle();
        @(negedge clk);
        check_val("full_hs2_core_gnt", 32'(core_gnt), 32'd1);
        next_cycle();
        vlsu_req = 1'b1;
        @(negedge clk);
        check_val("full_mem_req", 32'(mem_req), 32'd0);
        check_val("full_core_gnt", 32'(core_gnt), 32'd0);
        check_val("full_vlsu_gnt", 32'(vlsu_gnt), 32'd0);
        next_cycle();
        mem_rvalid = 1'b1; mem_rdata = 32'h55;
        @(negedge clk);
        check_val("pp_mem_req", 32'(mem_req), 32'd1);
        check_val("pp_vlsu_gnt", 32'(vlsu_gnt), 32'd1);
        check_val("pp_core_gnt", 32'(core_gnt), 32'd0);
        check_val("pp_core_rvalid", 32'(core_rvalid), 32'd1);
        check_val("pp_vlsu_rvalid", 32'(vlsu_rvalid), 32'd0);
        next_cycle();
        mem_rvalid = 1'b0;
        @(negedge clk);
        check_val("pp_still_full_req", 32'(mem_req), 32'd0);
        check_val("pp_still_full_cgnt", 32'(core_gnt), 32'd0);
        check_val("pp_still_full_vgnt", 32'(vlsu_gnt), 32'd0);
        next_cycle();
        core_req = 1'b0; vlsu_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
        @(negedge clk);
        check_val("drain1_core_rv", 32'(core_rvalid), 32'd1);
        check_val("drain1_vlsu_rv", 32'(vlsu_rvalid), 32'd0);
        next_cycle();
        @(negedge clk);
        check_val("drain2_core_rv", 32'(core_rvalid), 32'd0);
        check_val("drain2_vlsu_rv", 32'(vlsu_rvalid), 32'd1);

        // Vector lock for 4 handshakes, then the core wins the first unlocked cycle
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            vlsu_lock = (i < 4);
            core_req = (i < 5); vlsu_req = (i < 5); mem_gnt = (i < 5);
            mem_rvalid = (i > 0); mem_rdata = 32'hB0 + 32'(i);
            @(negedge clk);
            check_val($sformatf("lock%0d_core_gnt", i), 32'(core_gnt), 32'(i == 4));
            check_val($sformatf("lock%0d_vlsu_gnt", i), 32'(vlsu_gnt), 32'(i < 4));
            if (i < 4)
                check_val($sformatf("lock%0d_addr", i), mem_addr, 32'h2000);
            check_val($sformatf("lock%0d_core_rv", i), 32'(core_rvalid), 32'(i == 5));
            check_val($sformatf("lock%0d_vlsu_rv", i), 32'(vlsu_rvalid), 32'((i >= 1) && (i <= 4)));
        end

        // Response with nothing outstanding: dropped, error flag sticks
        next_cycle();
        idle();
        mem_rvalid = 1'b1; mem_rdata = 32'h77;
        @(negedge clk);
        check_val("stray_core_rv", 32'(core_rvalid), 32'd0);
        check_val("stray_vlsu_rv", 32'(vlsu_rvalid), 32'd0);
        check_val("stray_perr_pre", 32'(protocol_err), 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        check_val("stray_perr_set", 32'(protocol_err), 32'd1);
        next_cycle();
        core_req = 1'b1; core_addr = 32'h300; mem_gnt = 1'b1;
        @(negedge clk);
        check_val("stray_after_cgnt", 32'(core_gnt), 32'd1);
        next_cycle();
        idle();
        mem_rvalid = 1'b1; mem_rdata = 32'h88;
        @(negedge clk);
        check_val("stray_after_crv", 32'(core_rvalid), 32'd1);
        next_cycle();
        idle();
        @(negedge clk);
        check_val("stray_perr_hold", 32'(protocol_err), 32'd1);

        // Two vector IDs outstanding, then reset mid-operation
        next_cycle();
        vlsu_req = 1'b1; vlsu_addr = 32'h2000; mem_gnt = 1'b1;
        @(negedge clk);
        check_val("pre_rst_hs1", 32'(vlsu_gnt), 32'd1);
        next_cycle();
        @(negedge clk);
        check_val("pre_rst_hs2", 32'(vlsu_gnt), 32'd1);
        next_cycle();
        n_reset = 1'b0;
        setup_masters();
        core_req = 1'b1; vlsu_req = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h99;
        @(negedge clk);
        check_all_zero("rst2a");
        next_cycle();
        @(negedge clk);
        check_all_zero("rst2b");
        next_cycle();
        idle();
        n_reset = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h66;
        @(negedge clk);
        check_val("rst2_stray_core_rv", 32'(core_rvalid), 32'd0);
        check_val("rst2_stray_vlsu_rv", 32'(vlsu_rvalid), 32'd0);
        next_cycle();
        idle();
        setup_masters();
        core_req = 1'b1; vlsu_req = 1'b1; mem_gnt = 1'b1;
        @(negedge clk);
        check_val("rst2_tie_core_gnt", 32'(core_gnt), 32'd1);
        check_val("rst2_tie_vlsu_gnt", 32'(vlsu_gnt), 32'd0);
        check_val("rst2_perr", 32'(protocol_err), 32'd1);
        next_cycle();
        @(negedge clk);
        check_val("rst2_hs2_vlsu_gnt", 32'(vlsu_gnt), 32'd1);
        check_val("rst2_hs2_mem_req", 32'(mem_req), 32'd1);
        next_cycle();
        @(negedge clk);
        check_val("rst2_full_mem_req", 32'(mem_req), 32'd0);
        next_cycle();
        idle();
        mem_rvalid = 1'b1; mem_rdata = 32'h44;
        @(negedge clk);
        check_val("rst2_rsp1_core_rv", 32'(core_rvalid), 32'd1);
        check_val("rst2_rsp1_vlsu_rv", 32'(vlsu_rvalid), 32'd0);
        next_cycle();
        @(negedge clk);
        check_val("rst2_rsp2_core_rv", 32'(core_rvalid), 32'd0);
        check_val("rst2_rsp2_vlsu_rv", 32'(vlsu_rvalid), 32'd1);
        next_cycle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
